// File: rtl/keep_one_in_n_pkg.sv
// Shared constants for the keep-one-in-N packet decimator.
// Settings offsets, CTRL bit positions, reset defaults, counter width.
package keep_one_in_n_pkg;
   localparam int CNT_W = 16;

   localparam logic [7:0] SR_N_DEF    = 8'd131;
   localparam logic [7:0] SR_SPP_DEF  = 8'd132;
   localparam logic [7:0] SR_CTRL_DEF = 8'd133;

   localparam int CTRL_RESYNC_BIT = 0;
   localparam int CTRL_CLR_BIT    = 31;

   localparam logic [CNT_W-1:0] N_RST   = 16'd1;
   localparam logic [CNT_W-1:0] SPP_RST = 16'd256;

   // zero is not a usable factor/length; map it to one
   function automatic logic [CNT_W-1:0] nz(
      input logic [CNT_W-1:0] v
   );
      return (v == '0) ? 16'd1 : v;
   endfunction
endpackage

// File: rtl/keep_one_in_n_cfg.sv
// Pending/active config registers for the keep-one-in-N decimator.
// Ports: settings bus in, commit strobe in, active n/spp/resync out.
module keep_one_in_n_cfg
   import keep_one_in_n_pkg::*;
#(
   parameter logic [7:0] SR_N    = SR_N_DEF,
   parameter logic [7:0] SR_SPP  = SR_SPP_DEF,
   parameter logic [7:0] SR_CTRL = SR_CTRL_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic             commit,
   output logic [CNT_W-1:0] n,
   output logic [CNT_W-1:0] spp,
   output logic             resync
);
   logic [CNT_W-1:0] n_pend;
   logic [CNT_W-1:0] spp_pend;
   logic             resync_pend;

   logic unused_data_bits;
   assign unused_data_bits = ^set_data[31:16];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_pend      <= N_RST;
         spp_pend    <= SPP_RST;
         resync_pend <= 1'b0;
      end else if (set_stb) begin
         if (set_addr == SR_N)
            n_pend <= nz(set_data[CNT_W-1:0]);
         if (set_addr == SR_SPP)
            spp_pend <= nz(set_data[CNT_W-1:0]);
         if (set_addr == SR_CTRL)
            resync_pend <= set_data[CTRL_RESYNC_BIT];
      end
   end

   // Active copy only on an idle output-packet boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n      <= N_RST;
         spp    <= SPP_RST;
         resync <= 1'b0;
      end else if (commit) begin
         n      <= n_pend;
         spp    <= spp_pend;
         resync <= resync_pend;
      end
   end
endmodule

// File: rtl/axis_keep_one_in_n_pkt.sv
// Keeps one sample in every N and repacketizes into SPP-beat packets.
// Ports: clk/rst_n, settings bus, AXIS in (i_*), AXIS out (o_*),
// drop_count (live only with KEEP_ONE_IN_N_DROP_STATS_EN defined).
module axis_keep_one_in_n_pkt
   import keep_one_in_n_pkg::*;
#(
   parameter logic [7:0] SR_N    = SR_N_DEF,
   parameter logic [7:0] SR_SPP  = SR_SPP_DEF,
   parameter logic [7:0] SR_CTRL = SR_CTRL_DEF,
   parameter int         WIDTH   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic [31:0]      drop_count
);
   logic [CNT_W-1:0] n;
   logic [CNT_W-1:0] spp;
   logic             resync;
   logic [CNT_W-1:0] phase;
   logic [CNT_W-1:0] phase_nxt;
   logic [CNT_W-1:0] out_cnt;
   logic             accept;
   logic             keep;
   logic             drop;
   logic             out_last;
   logic             commit;

   assign i_tready = !o_tvalid || o_tready;
   assign accept   = i_tvalid && i_tready;
   assign keep     = accept && (phase == '0);
   assign drop     = accept && (phase != '0);
   assign out_last = (out_cnt == spp - 16'd1);
   assign commit   = (phase == '0) && (out_cnt == '0) && !accept;

   keep_one_in_n_cfg #(
      .SR_N    (SR_N),
      .SR_SPP  (SR_SPP),
      .SR_CTRL (SR_CTRL)
   ) u_cfg (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_stb  (set_stb),
      .set_addr (set_addr),
      .set_data (set_data),
      .commit   (commit),
      .n        (n),
      .spp      (spp),
      .resync   (resync)
   );

   // Resync on input tlast lands after the keep/drop decision
   always_comb begin
      phase_nxt = phase;
      if (accept) begin
         if (resync && i_tlast)
            phase_nxt = '0;
         else if (phase == n - 16'd1)
            phase_nxt = '0;
         else
            phase_nxt = phase + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase   <= '0;
         out_cnt <= '0;
      end else begin
         phase <= phase_nxt;
         if (keep)
            out_cnt <= out_last ? '0 : out_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_tvalid <= 1'b0;
         o_tlast  <= 1'b0;
         o_tdata  <= '0;
      end else if (keep) begin
         o_tvalid <= 1'b1;
         o_tlast  <= out_last;
         o_tdata  <= i_tdata;
      end else if (o_tready) begin
         o_tvalid <= 1'b0;
      end
   end

`ifdef KEEP_ONE_IN_N_DROP_STATS_EN
   logic        drop_clr;
   logic [31:0] drop_q;

   assign drop_clr = set_stb && (set_addr == SR_CTRL)
                     && set_data[CTRL_CLR_BIT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_q <= '0;
      else if (drop_clr)
         drop_q <= '0;
      else if (drop && (drop_q != 32'hFFFF_FFFF))
         drop_q <= drop_q + 32'd1;
   end

   assign drop_count = drop_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
   assign drop_count  = '0;
`endif
endmodule

// File: tb/tb_axis_keep_one_in_n_pkt.sv
// Scoreboard bench for axis_keep_one_in_n_pkt.
// Directed vectors; monitor pops expected beats on every output handshake.
module tb_axis_keep_one_in_n_pkt;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = '0;
   logic [31:0] set_data = '0;
   logic [31:0] i_tdata = '0;
   logic        i_tlast = 1'b0;
   logic        i_tvalid = 1'b0;
   logic        i_tready;
   logic [31:0] o_tdata;
   logic        o_tlast;
   logic        o_tvalid;
   logic        o_tready = 1'b1;
   logic [31:0] drop_count;

   localparam logic [7:0] A_N    = 8'd131;
   localparam logic [7:0] A_SPP  = 8'd132;
   localparam logic [7:0] A_CTRL = 8'd133;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } beat_t;

   beat_t exp_q[$];
   beat_t e;
   int    checks = 0;
   int    failures = 0;
   logic  stall_seen = 1'b0;
   logic [31:0] stall_d;
   logic  stall_l;
   logic  pat_en = 1'b0;
   logic [3:0] pat = 4'b1001;
   int    pat_k = 0;

   always #5 clk = ~clk;

   axis_keep_one_in_n_pkt dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_stb    (set_stb),
      .set_addr   (set_addr),
      .set_data   (set_data),
      .i_tdata    (i_tdata),
      .i_tlast    (i_tlast),
      .i_tvalid   (i_tvalid),
      .i_tready   (i_tready),
      .o_tdata    (o_tdata),
      .o_tlast    (o_tlast),
      .o_tvalid   (o_tvalid),
      .o_tready   (o_tready),
      .drop_count (drop_count)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s act=%0h req=%0h", nm, act, req);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_seen = 1'b0;
      end else begin
         chk("i_tready", {31'd0, i_tready},
             {31'd0, !(o_tvalid && !o_tready)});
         if (stall_seen) begin
            chk("stall_valid", {31'd0, o_tvalid}, 32'd1);
            chk("stall_data", o_tdata, stall_d);
            chk("stall_last", {31'd0, o_tlast}, {31'd0, stall_l});
         end
         if (o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat act=%0h req=none",
                        o_tdata);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", o_tdata, e.d);
               chk("out_last", {31'd0, o_tlast}, {31'd0, e.l});
            end
         end
         stall_seen = o_tvalid && !o_tready;
         stall_d    = o_tdata;
         stall_l    = o_tlast;
      end
   end

   // output backpressure pattern 1,0,0,1
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (pat_en) begin
            o_tready = pat[pat_k % 4];
            pat_k++;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = a;
      set_data = d;
      tick();
      set_stb  = 1'b0;
   endtask

   task automatic push(input logic [31:0] d, input logic l);
      exp_q.push_back('{d: d, l: l});
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      logic acc;
      int   b;
      i_tvalid = 1'b1;
      i_tdata  = d;
      i_tlast  = l;
      acc = 1'b0;
      b = 0;
      while (!acc && b < 50) begin
         @(negedge clk);
         acc = i_tready;
         tick();
         b++;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_timeout act=0 req=1");
      end
   endtask

   task automatic drain(input string nm);
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < 100) begin
         tick();
         b++;
      end
      chk(nm, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic cfg(input logic [15:0] n, input logic [15:0] spp,
                      input logic [31:0] ctrl);
      idle(1);
      wr(A_N, {16'd0, n});
      wr(A_SPP, {16'd0, spp});
      wr(A_CTRL, ctrl);
      idle(3);
   endtask

   initial begin
      do_reset();
      chk("rst_valid", {31'd0, o_tvalid}, 32'd0);
      chk("rst_last", {31'd0, o_tlast}, 32'd0);
      chk("rst_data", o_tdata, 32'd0);
      chk("rst_drop", drop_count, 32'd0);
      chk("rst_ready", {31'd0, i_tready}, 32'd1);

      // N=1 SPP=4, 1-cycle latency
      cfg(16'd1, 16'd4, 32'd0);
      for (int i = 0; i < 8; i++) begin
         push(i, (i == 3) || (i == 7));
         send(i, 1'b0);
         chk("latency_valid", {31'd0, o_tvalid}, 32'd1);
         chk("latency_data", o_tdata, i);
      end
      idle(1);
      drain("t1_drain");

      // N=4 SPP=2
      do_reset();
      cfg(16'd4, 16'd2, 32'd0);
      push(0, 0); push(4, 1); push(8, 0); push(12, 1);
      for (int i = 0; i < 16; i++) send(i, 1'b0);
      idle(2);
      drain("t2_drain");
`ifdef KEEP_ONE_IN_N_DROP_STATS_EN
      chk("drop_count12", drop_count, 32'd12);
      wr(A_CTRL, 32'h8000_0000);
      chk("drop_clear", drop_count, 32'd0);
`else
      chk("drop_tied0", drop_count, 32'd0);
`endif

      // N=3 resync on input tlast
      do_reset();
      cfg(16'd3, 16'd256, 32'd1);
      push(0, 0); push(3, 0); push(5, 0); push(8, 0);
      for (int i = 0; i < 10; i++) send(i, (i == 4) || (i == 9));
      idle(2);
      drain("t3_resync");

      // N=3 without resync
      do_reset();
      cfg(16'd3, 16'd256, 32'd0);
      push(0, 0); push(3, 0); push(6, 0); push(9, 0);
      for (int i = 0; i < 10; i++) send(i, (i == 4) || (i == 9));
      idle(2);
      drain("t3_noresync");

      // output backpressure
      do_reset();
      cfg(16'd1, 16'd4, 32'd0);
      pat_k = 0;
      pat_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push(32'h100 + i, (i == 3) || (i == 7));
         send(32'h100 + i, 1'b0);
      end
      idle(1);
      drain("t4_stall");
      pat_en = 1'b0;
      tick();
      o_tready = 1'b1;
      tick();

      // config change held until packet boundary
      do_reset();
      cfg(16'd1, 16'd4, 32'd0);
      push(0, 0);
      send(0, 1'b0);
      idle(1);
      wr(A_N, 32'd2);
      idle(3);
      push(1, 0); push(2, 0); push(3, 1);
      for (int i = 1; i < 4; i++) send(i, 1'b0);
      idle(3);
      push(4, 0); push(6, 0); push(8, 0); push(10, 1);
      for (int i = 4; i < 12; i++) send(i, 1'b0);
      idle(1);
      wr(A_N, 32'd0);
      idle(3);
      push(12, 0); push(13, 0);
      send(12, 1'b0);
      send(13, 1'b0);
      idle(2);
      drain("t5_cfg");

      // async reset while output pending
      cfg(16'd1, 16'd4, 32'd0);
      o_tready = 1'b0;
      send(32'h55, 1'b0);
      i_tvalid = 1'b0;
      chk("pre_rst_valid", {31'd0, o_tvalid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", {31'd0, o_tvalid}, 32'd0);
      chk("async_data", o_tdata, 32'd0);
      chk("async_last", {31'd0, o_tlast}, 32'd0);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      o_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(32'h200 + i, 1'b0);
         send(32'h200 + i, 1'b0);
      end
      idle(2);
      drain("t6_defaults");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
